// File: rtl/reg_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_arbiter_pkg
//  Description : Shared constants for the register-file write-back arbiter:
//                datapath widths, register-file write modes and requester
//                indices.
//  Revision    : 1.0  initial release
// ============================================================================
package reg_wb_arbiter_pkg;

    localparam int WIDTH        = 32;
    localparam int REG_ADDR_LEN = 5;

    // Register-file write modes; WM_ILLEGAL requests are dropped with err.
    typedef enum logic [1:0] {
        WM_WORD    = 2'd0,
        WM_HALF    = 2'd1,
        WM_BYTE    = 2'd2,
        WM_ILLEGAL = 2'd3
    } wmode_e;

    // Requester indices into the per-requester vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int NUM_REQ = 2;

endpackage
`default_nettype wire

// File: rtl/reg_wb_arbiter_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo
//  Description : DEPTH-entry write-back request FIFO. Stores {addr,data,mode}
//                per entry and exposes every entry's valid bit and address so
//                the parent can answer register hazard queries.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                i_push              enqueue i_addr/i_data/i_mode (ignored when full)
//                i_pop               dequeue the head (ignored when empty)
//                o_full, o_empty     occupancy flags
//                o_head_*            head entry contents
//                o_entry_valid       per-slot valid bits
//                o_entry_addr        per-slot addresses, slot i at [i*ADDR_LEN +: ADDR_LEN]
//  Revision    : 1.0  initial release
// ============================================================================
module wb_fifo #(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 5,
    parameter int DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [ADDR_LEN-1:0]      i_addr,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [1:0]               i_mode,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [ADDR_LEN-1:0]      o_head_addr,
    output logic [WIDTH-1:0]         o_head_data,
    output logic [1:0]               o_head_mode,
    output logic [DEPTH-1:0]         o_entry_valid,
    output logic [DEPTH*ADDR_LEN-1:0] o_entry_addr
);

    localparam int                  c_ptr_w     = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0]  c_ptr_one   = 1;
    localparam logic [c_ptr_w:0]    c_full_cnt  = (c_ptr_w+1)'(DEPTH);

    logic [ADDR_LEN-1:0] r_addr [DEPTH];
    logic [WIDTH-1:0]    r_data [DEPTH];
    logic [1:0]          r_mode [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_full_cnt);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Payload storage carries no reset; slot validity is tracked by r_valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_addr[r_wr_ptr] <= i_addr;
            r_data[r_wr_ptr] <= i_data;
            r_mode[r_wr_ptr] <= i_mode;
        end
    end

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH naturally.
    // A push never targets the slot being popped: a push needs a free slot
    // and a pop needs an occupied one, so wr_ptr != rd_ptr whenever both fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            if (w_do_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_ptr_one;
            end
            r_count <= r_count + {{c_ptr_w{1'b0}}, w_do_push}
                               - {{c_ptr_w{1'b0}}, w_do_pop};
        end
    end

    assign o_head_addr   = r_addr[r_rd_ptr];
    assign o_head_data   = r_data[r_rd_ptr];
    assign o_head_mode   = r_mode[r_rd_ptr];
    assign o_entry_valid = r_valid;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign o_entry_addr[gi*ADDR_LEN +: ADDR_LEN] = r_addr[gi];
    end

endmodule
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_wb_arbiter
//  Description : Shares the register file's single write port between the
//                ALU (requester 0) and memory-load (requester 1) write-back
//                paths. Each requester has a DEPTH-entry FIFO; one entry is
//                popped per cycle onto a registered write port. A hazard query
//                reports whether a register still has a write in flight.
//  Ports       : clk, rst                  clock, synchronous active-high reset
//                req_valid/req_ready [1:0] per-requester handshake
//                req_addr/data/mode{0,1}   request payload (mode 3 is illegal)
//                w_en, rc, dataC, w_mode   registered register-file write port
//                qa / q_pending            hazard query address / result
//                err                       one-cycle pulse on an illegal drop
//                busy                      FIFO occupied or write on the port
//  Config      : define REG_WB_RR_EN for round-robin arbitration; otherwise
//                fixed priority MEM over ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_wb_arbiter #(
    parameter int WIDTH    = reg_wb_arbiter_pkg::WIDTH,
    parameter int ADDR_LEN = reg_wb_arbiter_pkg::REG_ADDR_LEN,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [ADDR_LEN-1:0] req_addr0,
    input  logic [ADDR_LEN-1:0] req_addr1,
    input  logic [WIDTH-1:0]    req_data0,
    input  logic [WIDTH-1:0]    req_data1,
    input  logic [1:0]          req_mode0,
    input  logic [1:0]          req_mode1,
    output logic                w_en,
    output logic [ADDR_LEN-1:0] rc,
    output logic [WIDTH-1:0]    dataC,
    output logic [1:0]          w_mode,
    input  logic [ADDR_LEN-1:0] qa,
    output logic                q_pending,
    output logic                err,
    output logic                busy
);

    import reg_wb_arbiter_pkg::*;

    logic [ADDR_LEN-1:0]       w_req_addr [NUM_REQ];
    logic [WIDTH-1:0]          w_req_data [NUM_REQ];
    logic [1:0]                w_req_mode [NUM_REQ];

    logic [NUM_REQ-1:0]        w_accept;
    logic [NUM_REQ-1:0]        w_push;
    logic [NUM_REQ-1:0]        w_illegal;
    logic [NUM_REQ-1:0]        w_full;
    logic [NUM_REQ-1:0]        w_empty;
    logic [NUM_REQ-1:0]        w_pop;

    logic [ADDR_LEN-1:0]       w_head_addr [NUM_REQ];
    logic [WIDTH-1:0]          w_head_data [NUM_REQ];
    logic [1:0]                w_head_mode [NUM_REQ];
    logic [DEPTH-1:0]          w_ent_valid [NUM_REQ];
    logic [DEPTH*ADDR_LEN-1:0] w_ent_addr  [NUM_REQ];

    logic                      w_match;

    logic                      r_w_en;
    logic [ADDR_LEN-1:0]       r_rc;
    logic [WIDTH-1:0]          r_data;
    logic [1:0]                r_mode;
    logic                      r_err;

    assign w_req_addr[REQ_ALU] = req_addr0;
    assign w_req_addr[REQ_MEM] = req_addr1;
    assign w_req_data[REQ_ALU] = req_data0;
    assign w_req_data[REQ_MEM] = req_data1;
    assign w_req_mode[REQ_ALU] = req_mode0;
    assign w_req_mode[REQ_MEM] = req_mode1;

    // Per-requester accept/drop decode and FIFO. Writes to r0 are dropped
    // silently before the mode is even considered; illegal modes to any
    // other register are dropped and flagged.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_ready[gi] = !w_full[gi] && !rst;
        assign w_accept[gi]  = req_valid[gi] && req_ready[gi];
        assign w_push[gi]    = w_accept[gi] && (w_req_addr[gi] != '0)
                               && (w_req_mode[gi] != WM_ILLEGAL);
        assign w_illegal[gi] = w_accept[gi] && (w_req_addr[gi] != '0)
                               && (w_req_mode[gi] == WM_ILLEGAL);

        wb_fifo #(
            .WIDTH    (WIDTH),
            .ADDR_LEN (ADDR_LEN),
            .DEPTH    (DEPTH)
        ) u_fifo (
            .clk           (clk),
            .rst           (rst),
            .i_push        (w_push[gi]),
            .i_pop         (w_pop[gi]),
            .i_addr        (w_req_addr[gi]),
            .i_data        (w_req_data[gi]),
            .i_mode        (w_req_mode[gi]),
            .o_full        (w_full[gi]),
            .o_empty       (w_empty[gi]),
            .o_head_addr   (w_head_addr[gi]),
            .o_head_data   (w_head_data[gi]),
            .o_head_mode   (w_head_mode[gi]),
            .o_entry_valid (w_ent_valid[gi]),
            .o_entry_addr  (w_ent_addr[gi])
        );
    end

`ifdef REG_WB_RR_EN
    // Last winner: 1 = MEM. Resetting to MEM lets the ALU win the first tie.
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|w_pop) begin
            r_last <= w_pop[REQ_MEM];
        end
    end
`endif

    // Grant: at most one pop per cycle, only from non-empty FIFOs.
    always_comb begin
        w_pop = '0;
        if (!w_empty[REQ_MEM] && !w_empty[REQ_ALU]) begin
`ifdef REG_WB_RR_EN
            if (r_last) begin
                w_pop[REQ_ALU] = 1'b1;
            end else begin
                w_pop[REQ_MEM] = 1'b1;
            end
`else
            w_pop[REQ_MEM] = 1'b1;
`endif
        end else if (!w_empty[REQ_MEM]) begin
            w_pop[REQ_MEM] = 1'b1;
        end else if (!w_empty[REQ_ALU]) begin
            w_pop[REQ_ALU] = 1'b1;
        end
    end

    // Registered write port; address/data/mode hold when nothing pops.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_en <= 1'b0;
            r_rc   <= '0;
            r_data <= '0;
            r_mode <= '0;
            r_err  <= 1'b0;
        end else begin
            r_err  <= |w_illegal;
            r_w_en <= |w_pop;
            if (w_pop[REQ_MEM]) begin
                r_rc   <= w_head_addr[REQ_MEM];
                r_data <= w_head_data[REQ_MEM];
                r_mode <= w_head_mode[REQ_MEM];
            end else if (w_pop[REQ_ALU]) begin
                r_rc   <= w_head_addr[REQ_ALU];
                r_data <= w_head_data[REQ_ALU];
                r_mode <= w_head_mode[REQ_ALU];
            end
        end
    end

    // Hazard match over every buffered entry plus the write on the port.
    always_comb begin
        w_match = r_w_en && (r_rc == qa);
        for (int r = 0; r < NUM_REQ; r++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_ent_valid[r][e] && (w_ent_addr[r][e*ADDR_LEN +: ADDR_LEN] == qa)) begin
                    w_match = 1'b1;
                end
            end
        end
    end

    assign q_pending = (qa != '0) && w_match;
    assign busy      = !(&w_empty) || r_w_en;
    assign w_en      = r_w_en;
    assign rc        = r_rc;
    assign dataC     = r_data;
    assign w_mode    = r_mode;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port (rc, dataC, w_en, w_mode) between two write-back requesters: requester 0 = ALU result, requester 1 = memory load.
- Each requester gets a DEPTH-entry FIFO.
- An arbiter pops at most one entry per cycle and drives the write port from registers.
- A query port reports whether a register has a write still in flight, so issue logic can stall on RAW/WAW hazards.

Parameters:
- WIDTH, 32, data width; matches `WIDTH.
- ADDR_LEN, 5, register address width; matches `REG_ADDR_LEN.
- DEPTH, 2, entries per requester FIFO; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester write request; bit i = requester i.
- req_ready  out  2  per-requester accept; bit i = !full_i && !rst.
- req_addr0, req_addr1  in  ADDR_LEN each  destination register.
- req_data0, req_data1  in  WIDTH each  write data.
- req_mode0, req_mode1  in  2 each  0 = word, 1 = halfword, 2 = byte, 3 = illegal.
- w_en  out  1  register-file write enable.
- rc  out  ADDR_LEN  register-file write address.
- dataC  out  WIDTH  register-file write data.
- w_mode  out  2  register-file write mode.
- qa  in  ADDR_LEN  hazard query address.
- q_pending  out  1  a write to qa is buffered or on the port.
- err  out  1  one-cycle pulse when an illegal request is dropped.
- busy  out  1  any FIFO non-empty, or w_en high.

Behaviour:
- Reset:
  - Both FIFOs flushed (pointers and counts zeroed); in-flight entries are discarded, including mid-burst.
  - w_en, rc, dataC, w_mode, err forced to 0; req_ready = 0 while rst is high; arbitration pointer set to requester 1.
- Accept:
  - Request i is accepted at a posedge when req_valid[i] && req_ready[i].
  - No pass-through: a full FIFO stays not-ready even if it pops in the same cycle.
- Drop rules:
  - Accepted requests with addr == 0 are discarded silently; no enqueue, no err.
  - Accepted requests with mode == 3 are discarded, and err pulses the following cycle.
  - If both requesters are dropped in the same cycle, err is still a single pulse.
- Arbitration:
  - Each cycle, the heads of the non-empty FIFOs are candidates.
  - Default is fixed priority, requester 1 (MEM) over requester 0 (ALU).
  - The winner pops at the posedge.
- Write port:
  - At the pop edge, w_en <= 1 and rc/dataC/w_mode <= the head entry.
  - With no pop, w_en <= 0 and rc/dataC/w_mode hold their last value.
  - The register file writes at the following posedge.
- Latency: a request accepted at edge k pops no earlier than edge k+1, so w_en is high in cycle k+1..k+2 and the register file is updated at edge k+2.
- Throughput: one write per cycle sustained; both FIFOs drain in count0 + count1 cycles.
- Ordering:
  - Per-requester FIFO order is preserved.
  - Across requesters the order is arbitration order only; upstream must use q_pending to avoid cross-requester WAW.
- Simultaneous push and pop on the same FIFO: count is unchanged and the head advances.
- Pointers wrap modulo DEPTH.
- q_pending (combinational):
  - Asserts when qa != 0 and qa matches either any valid FIFO entry or (w_en && rc == qa).
  - Always 0 for qa == 0.
  - Entries accepted this cycle are not visible until the next cycle.

Optional Feature:
- REG_WB_RR_EN defined:
  - Round-robin arbitration; when both FIFOs are non-empty, grant the requester other than the last winner.
  - The last-winner register resets to 1, so the ALU wins first.
- REG_WB_RR_EN undefined: fixed priority MEM over ALU; the ALU can starve while MEM is continuously non-empty.

Decomposition:
- params.v carries the shared constants:
  - WIDTH and REG_ADDR_LEN.
  - Write-mode constants WM_WORD = 0, WM_HALF = 1, WM_BYTE = 2.
  - Requester indices REQ_ALU = 0, REQ_MEM = 1.
- One sub-module, wb_fifo:
  - Parameterised by WIDTH, ADDR_LEN and DEPTH.
  - Exposes push, pop, full, empty and head.
  - Exposes a per-entry valid and address vector for the q_pending match.
- Instantiated twice; the arbiter, output register and err logic sit in the top module.

Test Plan:
- Single write: after reset, ALU request addr = 5, data = 0xDEADBEEF, mode = 0, accepted at edge k -> w_en = 1, rc = 5, dataC = 0xDEADBEEF during cycle k+1..k+2; busy falls after edge k+2.
- Collision: both requesters valid in the same cycle, ALU (3, 0x11) and MEM (4, 0x22) -> default build writes MEM first, then ALU, on back-to-back cycles.
  - With REG_WB_RR_EN and sustained traffic on both requesters, the grants alternate ALU, MEM, ALU, and so on.
- Backpressure: hold the ALU valid for 4 cycles while MEM is continuously busy (fixed priority), DEPTH = 2 -> req_ready[0] drops after 2 accepts.
  - No entry is lost or duplicated; all 4 ALU writes appear in order once MEM idles.
- Drops:
  - addr = 0 is accepted with no w_en and no err.
  - mode = 3 to addr 7 is accepted with no w_en; err pulses exactly once.
- Hazard query: enqueue a write to r9 and hold qa = 9 -> q_pending = 1 from the cycle after accept through the cycle w_en is high with rc = 9, then 0; qa = 0 always gives 0.
- Reset mid-operation: fill both FIFOs, then assert rst for 1 cycle -> no further w_en, busy = 0, req_ready = 2'b11 in the first cycle after rst deasserts.
